hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/mips_pkg.sv | 8 +
 rtl/load_use_detect.sv | 17 +
 rtl/hazard_ctrl.sv | 98 +++++++++
 tb/tb_hazard_ctrl.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: opcode constants and hazard controller state encoding shared across the pipeline
package mips_pkg;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_LW    = 6'b100011;
  typedef enum logic [1:0] {RUN, STALL, FREEZE} state_t;
endpackage

// File: rtl/load_use_detect.sv
// load_use_detect: flags a decode-stage instruction that reads the register an EX-stage load is writing
module load_use_detect
  import mips_pkg::*;
(
  input  logic       id_valid,
  input  logic [5:0] id_opcode,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       ex_memread,
  input  logic [4:0] ex_rt,
  output logic       hazard
);
  logic uses_rt;
  assign uses_rt = id_opcode == OP_RTYPE || id_opcode == OP_BEQ || id_opcode == OP_SW;
  assign hazard  = id_valid && ex_memread && ex_rt != 5'd0 &&
                   (ex_rt == id_rs || (ex_rt == id_rt && uses_rt));
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline stall/flush/freeze control with optional perf counters (HAZARD_CTRL_PERF_EN)
module hazard_ctrl
  import mips_pkg::*;
#(
  parameter int STALL_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [5:0]  id_opcode,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        ex_memread,
  input  logic [4:0]  ex_rt,
  input  logic        mem_branch_taken,
  input  logic        dmem_busy,
  output logic        pc_write,
  output logic        ifid_write,
  output logic        idex_write,
  output logic        exmem_write,
  output logic        idex_bubble,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic        exmem_flush,
  output logic [31:0] perf_stall,
  output logic [31:0] perf_flush
);
  localparam logic [2:0] CNT_INIT = STALL_CYCLES > 1 ? 3'(STALL_CYCLES - 2) : 3'd0;
  state_t     state_q, state_d, saved_q, saved_d, eff;
  logic [2:0] cnt_q, cnt_d;
  logic       hazard;
  load_use_detect u_detect (
    .id_valid  (id_valid),
    .id_opcode (id_opcode),
    .id_rs     (id_rs),
    .id_rt     (id_rt),
    .ex_memread(ex_memread),
    .ex_rt     (ex_rt),
    .hazard    (hazard)
  );
  // Leaving FREEZE resumes the saved state within the same cycle, so decisions use the effective state
  always_comb begin
    eff = state_q == FREEZE ? saved_q : state_q;
    state_d = state_q;
    saved_d = saved_q;
    cnt_d = cnt_q;
    {pc_write, ifid_write, idex_write, exmem_write} = 4'hF;
    {idex_bubble, ifid_flush, idex_flush, exmem_flush} = 4'h0;
    if (rst) begin
      {pc_write, ifid_write, idex_write, exmem_write} = 4'h0;
    end else if (mem_branch_taken) begin
      {ifid_flush, idex_flush, exmem_flush} = 3'b111;
      state_d = RUN;
      cnt_d = 3'd0;
    end else if (dmem_busy) begin
      {pc_write, ifid_write, idex_write, exmem_write} = 4'h0;
      state_d = FREEZE;
      saved_d = eff;
    end else if (eff == STALL || hazard) begin
      {pc_write, ifid_write} = 2'b00;
      idex_bubble = 1'b1;
      state_d = eff == STALL ? (cnt_q == 3'd0 ? RUN : STALL) : (STALL_CYCLES > 1 ? STALL : RUN);
      cnt_d = eff == STALL ? (cnt_q == 3'd0 ? 3'd0 : cnt_q - 3'd1) : CNT_INIT;
    end else begin
      state_d = RUN;
    end
  end
  // State, remaining stall count and pre-freeze state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      saved_q <= RUN;
      cnt_q <= 3'd0;
    end else begin
      state_q <= state_d;
      saved_q <= saved_d;
      cnt_q <= cnt_d;
    end
  end
`ifdef HAZARD_CTRL_PERF_EN
  logic [31:0] perf_stall_q, perf_flush_q;
  // Saturating event counters for bubble cycles and taken-branch flushes
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      perf_stall_q <= perf_stall_q + 32'(idex_bubble && perf_stall_q != '1);
      perf_flush_q <= perf_flush_q + 32'(mem_branch_taken && perf_flush_q != '1);
    end
  end
  assign perf_stall = perf_stall_q;
  assign perf_flush = perf_flush_q;
`else
  assign perf_stall = '0;
  assign perf_flush = '0;
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: three controller instances (stall lengths 1, 3, 4) checked against a stall-count model
module tb_hazard_ctrl;
`ifdef HAZARD_CTRL_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif
  localparam logic [7:0] P_RST = 8'b0000_0000, P_BR = 8'b1111_0111, P_BUSY = 8'b0000_0000,
                         P_STALL = 8'b0011_1000, P_RUN = 8'b1111_0000;
  logic clk = 1'b0, rst = 1'b1, id_valid, ex_memread, br, busy;
  logic [5:0] id_opcode;
  logic [4:0] id_rs, id_rt, ex_rt;
  logic [7:0] ctl [3];
  logic [31:0] ps_o [3], pf_o [3];
  int n_chk = 0, n_fail = 0;
  bit chk_en = 1'b0;
  int sc [3] = '{1, 3, 4};
  int rem [3];
  bit frz [3];
  logic [31:0] ps_m [3], pf_m [3];
  always #5 clk = ~clk;
  for (genvar g = 0; g < 3; g++) begin : g_dut
    hazard_ctrl #(.STALL_CYCLES(g == 0 ? 1 : g == 1 ? 3 : 4)) dut (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode), .id_rs(id_rs), .id_rt(id_rt),
      .ex_memread(ex_memread), .ex_rt(ex_rt), .mem_branch_taken(br), .dmem_busy(busy),
      .pc_write(ctl[g][7]), .ifid_write(ctl[g][6]), .idex_write(ctl[g][5]), .exmem_write(ctl[g][4]),
      .idex_bubble(ctl[g][3]), .ifid_flush(ctl[g][2]), .idex_flush(ctl[g][1]), .exmem_flush(ctl[g][0]),
      .perf_stall(ps_o[g]), .perf_flush(pf_o[g]));
  end
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask
  function automatic bit hz();
    bit reads_rt = id_opcode == 6'd0 || id_opcode == 6'd4 || id_opcode == 6'd43;
    return id_valid && ex_memread && ex_rt != 0 && (ex_rt == id_rs || (ex_rt == id_rt && reads_rt));
  endfunction
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      logic [7:0] e;
      if (rst) e = P_RST;
      else if (br) e = P_BR;
      else if (busy) e = P_BUSY;
      else if (rem[i] > 0 || hz()) e = P_STALL;
      else e = P_RUN;
      if (chk_en) begin
        chk($sformatf("ctl%0d", i), 32'(ctl[i]), 32'(e));
        chk($sformatf("perf_stall%0d", i), ps_o[i], PERF ? ps_m[i] : 32'd0);
        chk($sformatf("perf_flush%0d", i), pf_o[i], PERF ? pf_m[i] : 32'd0);
      end
      if (rst) begin
        rem[i] = 0; frz[i] = 0; ps_m[i] = 0; pf_m[i] = 0;
      end else if (br) begin
        rem[i] = 0; frz[i] = 0;
        if (pf_m[i] != 32'hFFFF_FFFF) pf_m[i]++;
      end else if (busy) begin
        frz[i] = 1;
      end else begin
        frz[i] = 0;
        if (e == P_STALL) begin
          rem[i] = rem[i] > 0 ? rem[i] - 1 : sc[i] - 1;
          if (ps_m[i] != 32'hFFFF_FFFF) ps_m[i]++;
        end
      end
    end
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    {id_valid, ex_memread, br, busy} = 4'b0;
    id_opcode = 6'd8; id_rs = 5'd0; id_rt = 5'd0; ex_rt = 5'd0;
  endtask
  task automatic load_use(input logic [4:0] r);
    id_valid = 1; ex_memread = 1; ex_rt = r; id_rs = r; id_opcode = 6'd8;
  endtask
  task automatic do_reset();
    rst = 1; idle(); step(); rst = 0; #1;
  endtask
  initial begin
    idle();
    step(); step();
    chk_en = 1;
    rst = 0; #1;
    chk("reset_run", 32'(ctl[1]), 32'(P_RUN));
    load_use(5'd5); #1;
    chk("lu_sc1_stall", 32'(ctl[0]), 32'(P_STALL));
    step(); idle(); #1;
    chk("lu_sc1_after", 32'(ctl[0]), 32'(P_RUN));
    chk("lu_sc1_perf", ps_o[0], PERF ? 32'd1 : 32'd0);
    repeat (5) step();
    id_valid = 1; ex_memread = 1; ex_rt = 0; id_rs = 0; #1;
    chk("r0_no_stall", 32'(ctl[2]), 32'(P_RUN));
    ex_rt = 7; id_rt = 7; id_rs = 3; id_opcode = 6'b001000; #1;
    chk("addi_rt_no_stall", 32'(ctl[0]), 32'(P_RUN));
    id_opcode = 6'b101011; #1;
    chk("sw_rt_stall", 32'(ctl[0]), 32'(P_STALL));
    step(); idle(); repeat (5) step();
    do_reset();
    load_use(5'd5); #1;
    chk("fz_first", 32'(ctl[1]), 32'(P_STALL));
    step(); idle(); busy = 1;
    for (int k = 0; k < 4; k++) begin
      #1 chk($sformatf("fz_hold%0d", k), 32'(ctl[1]), 32'(P_BUSY));
      step();
    end
    busy = 0; #1;
    chk("fz_rel1", 32'(ctl[1]), 32'(P_STALL));
    step();
    chk("fz_rel2", 32'(ctl[1]), 32'(P_STALL));
    step();
    chk("fz_done", 32'(ctl[1]), 32'(P_RUN));
    chk("fz_perf", ps_o[1], PERF ? 32'd3 : 32'd0);
    do_reset();
    load_use(5'd9); br = 1; #1;
    chk("br_hz", 32'(ctl[2]), 32'(P_BR));
    step(); idle(); #1;
    chk("br_next", 32'(ctl[2]), 32'(P_RUN));
    chk("br_perf", pf_o[2], PERF ? 32'd1 : 32'd0);
    chk("br_perf_stall", ps_o[2], 32'd0);
    do_reset();
    load_use(5'd4); step(); idle(); step();
    rst = 1; #1;
    chk("rst_mid_stall", 32'(ctl[2]), 32'(P_RST));
    step(); rst = 0; #1;
    chk("rst_after", 32'(ctl[2]), 32'(P_RUN));
    chk("rst_perf", ps_o[2], 32'd0);
    for (int k = 0; k < 3000; k++) begin
      logic [5:0] ops [5] = '{6'd0, 6'd4, 6'd43, 6'd35, 6'd8};
      rst = $urandom_range(63) == 0;
      br = $urandom_range(7) == 0;
      busy = $urandom_range(5) == 0;
      id_valid = $urandom_range(3) != 0;
      ex_memread = $urandom_range(1) == 1;
      id_opcode = ops[$urandom_range(4)];
      id_rs = 5'($urandom_range(3));
      id_rt = 5'($urandom_range(3));
      ex_rt = 5'($urandom_range(3));
      step();
    end
    rst = 0; idle(); step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
